// File: rtl/alu_muldiv_if.sv
// rtl/alu_muldiv_if.sv - Command, write-port and result bundle for the iterative multiply/divide unit
//
// Purpose: groups the datapath-facing signals of alu_muldiv.
// Ports (master = datapath/controller side, slave = alu_muldiv):
//   Start, MulDiv, Sign, A, B      operation request (master -> slave)
//   WrHI, WrLO, WData              MTHI/MTLO writes (master -> slave)
//   Busy, Done, DivZero, HI, LO    status and result registers (slave -> master)
interface alu_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             Start;
    logic             MulDiv;
    logic             Sign;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             WrHI;
    logic             WrLO;
    logic [WIDTH-1:0] WData;
    logic             Busy;
    logic             Done;
    logic             DivZero;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    modport master (
        output Start, MulDiv, Sign, A, B, WrHI, WrLO, WData,
        input  Busy, Done, DivZero, HI, LO
    );

    modport slave (
        input  Start, MulDiv, Sign, A, B, WrHI, WrLO, WData,
        output Busy, Done, DivZero, HI, LO
    );
endinterface

// File: rtl/alu_muldiv.sv
// rtl/alu_muldiv.sv - Iterative one-bit-per-cycle multiply/divide unit with HI/LO registers
//
// Purpose: shift-add multiply and restoring divide on operand magnitudes, WIDTH
//   iterations, followed by a sign fix-up cycle that writes HI/LO and pulses Done.
// Ports:
//   clk    clock, rising edge
//   reset  synchronous, active-high; aborts any running operation
//   bus    alu_muldiv_if.slave (Start/MulDiv/Sign/A/B in, WrHI/WrLO/WData in,
//          Busy/Done/DivZero/HI/LO out)
module alu_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         reset,
    alu_muldiv_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;

    logic [1:0]       state;
    logic [CW-1:0]    count;
    logic             op_div;
    logic             neg_lo;     // negate product (mult) or quotient (div)
    logic             neg_hi;     // remainder takes the sign of the dividend
    logic             div_zero;

    // Working registers. Multiply: {acc_hi, acc_lo} is the partial product with the
    // multiplier shifting out of acc_lo. Divide: acc_hi is the partial remainder and
    // acc_lo shifts dividend bits out the top while quotient bits shift in the bottom.
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] opb;

    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             done_q;
    logic             dz_q;

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic [2*WIDTH-1:0] product;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

    always_comb begin
        a_neg = bus.Sign & bus.A[WIDTH-1];
        b_neg = bus.Sign & bus.B[WIDTH-1];
        a_mag = a_neg ? -bus.A : bus.A;
        b_mag = b_neg ? -bus.B : bus.B;

        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        // A set top bit means the trial subtraction borrowed: keep the shifted remainder.
        div_diff  = div_shift - {1'b0, opb};

        product  = {acc_hi, acc_lo};
        prod_fix = neg_lo ? -product : product;
        quo_fix  = neg_lo ? -acc_lo : acc_lo;
        rem_fix  = neg_hi ? -acc_hi : acc_hi;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            count    <= '0;
            op_div   <= 1'b0;
            neg_lo   <= 1'b0;
            neg_hi   <= 1'b0;
            div_zero <= 1'b0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            opb      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.Start) begin
                        acc_hi   <= '0;
                        acc_lo   <= a_mag;
                        opb      <= b_mag;
                        op_div   <= bus.MulDiv;
                        neg_lo   <= a_neg ^ b_neg;
                        neg_hi   <= a_neg;
                        div_zero <= bus.MulDiv & (bus.B == '0);
                        dz_q     <= 1'b0;
                        count    <= '0;
                        state    <= CALC;
                    end else begin
                        if (bus.WrHI) hi_q <= bus.WData;
                        if (bus.WrLO) lo_q <= bus.WData;
                    end
                end
                CALC: begin
                    if (op_div) begin
                        acc_hi <= div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
                        acc_lo <= {acc_lo[WIDTH-2:0], ~div_diff[WIDTH]};
                    end else begin
                        acc_hi <= mul_sum[WIDTH:1];
                        acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                    end
                    count <= count + CW'(1);
                    if (count == CW'(WIDTH-1)) state <= FIX;
                end
                FIX: begin
                    if (op_div) begin
                        // With B == 0 every trial succeeds, so the remainder ends as |A|;
                        // re-applying A's sign restores the original dividend in HI.
                        hi_q <= rem_fix;
                        lo_q <= div_zero ? '1 : quo_fix;
                        dz_q <= div_zero;
                    end else begin
                        hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_q <= prod_fix[WIDTH-1:0];
                    end
                    done_q <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.Busy    = (state != IDLE);
    assign bus.Done    = done_q;
    assign bus.DivZero = dz_q;
    assign bus.HI      = hi_q;
    assign bus.LO      = lo_q;
endmodule
